// File: rtl/mld_7_4_pkg.sv
// Shared constants and FSM encoding for the (7,4) cyclic code blocks.
// Holds code geometry, the default generator g(x)=1+x+x^3 and encoder states.
package mld_7_4_pkg;

    localparam int N = 7;
    localparam int K = 4;
    localparam int R = 3;

    // Low coefficients {g2,g1,g0}; the x^3 term is implied.
    localparam logic [R-1:0] GEN_POLY_DEFAULT = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MSG  = 2'd1,
        ST_PAR  = 2'd2
    } enc_state_t;

    // Coefficient of x^(R+i) reduced mod g(x) is not needed here; this
    // helper gives the bit index carried on a given frame slot (c6 first).
    function automatic logic [2:0] slot_to_index(input logic [2:0] slot);
        return 3'(N - 1) - slot;
    endfunction

endpackage

// File: rtl/mld_7_4_encoder_lfsr.sv
// cyclic_parity_lfsr: W-bit LFSR divider by g(x), shared with syndrome logic.
// Ports: clk, reset (async low), clear, shift, gate (1 = feedback off),
// fb_in (data bit), par (register b0..b[W-1]), par_shift (value after a shift).
module cyclic_parity_lfsr
    import mld_7_4_pkg::*;
#(
    parameter int             W = R,
    parameter logic [W-1:0]   G = GEN_POLY_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         shift,
    input  logic         gate,
    input  logic         fb_in,
    output logic [W-1:0] par,
    output logic [W-1:0] par_shift
);

    logic f;

    always_comb begin
        f = gate ? 1'b0 : (fb_in ^ par[W-1]);
        par_shift = '0;
        par_shift[0] = f & G[0];
        for (int i = 1; i < W; i++) begin
            par_shift[i] = par[i-1] ^ (f & G[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par <= '0;
        end else if (clear) begin
            par <= '0;
        end else if (shift) begin
            par <= par_shift;
        end
    end

endmodule

// File: rtl/mld_7_4_encoder.sv
// Systematic (7,4) cyclic encoder: 4-bit message in, 7-bit serial frame out
// (c6 first) with tx_load strobe, plus the completed codeword in parallel.
// Ports: clk, reset (async low), msg_valid/msg/msg_ready handshake,
// tx_bit/tx_load serial stream, codeword [0:6] = c0..c6, codeword_valid pulse.
// Optional macro MLD_ENC_ERROR_INJECT_EN adds err_mask [0:6]: emitted c_i is
// XORed with err_mask[i]; codeword still reports the clean word.
module mld_7_4_encoder
    import mld_7_4_pkg::*;
#(
    parameter logic [R-1:0] GEN_POLY = GEN_POLY_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         msg_valid,
    input  logic [K-1:0] msg,
`ifdef MLD_ENC_ERROR_INJECT_EN
    input  logic [0:N-1] err_mask,
`endif
    output logic         msg_ready,
    output logic         tx_bit,
    output logic         tx_load,
    output logic [0:N-1] codeword,
    output logic         codeword_valid
);

    enc_state_t   state;
    enc_state_t   state_n;
    logic [1:0]   cnt;
    logic [1:0]   cnt_n;
    logic [K-1:0] msg_q;
    logic [R-1:0] par_q;

    logic         accept;
    logic         tx_clean_n;
    logic         tx_n;
    logic [2:0]   slot_n;
    logic [2:0]   idx_n;
    logic         done;
    logic         capture_par;
    logic         lfsr_clr;
    logic         lfsr_shift;
    logic         lfsr_gate;
    logic         fb_bit;
    logic [R-1:0] par;
    logic [R-1:0] par_shift;
    logic [0:N-1] err_cur;

`ifdef MLD_ENC_ERROR_INJECT_EN
    logic [0:N-1] err_q;

    // The first bit of a frame is chosen on the accepting edge, before
    // the mask has been latched, so take it straight from the port then.
    assign err_cur = accept ? err_mask : err_q;
`else
    assign err_cur = '0;
`endif

    // Ready in idle and on the last parity slot for gap-free frames.
    assign msg_ready = (state == ST_IDLE) ||
                       ((state == ST_PAR) && (cnt == 2'd2));
    assign accept    = msg_valid & msg_ready;
    assign tx_load   = (state != ST_IDLE);

    // Message bit currently on the line feeds the divider.
    assign fb_bit    = msg_q[2'd3 - cnt];

    cyclic_parity_lfsr #(
        .W (R),
        .G (GEN_POLY)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .clear     (lfsr_clr),
        .shift     (lfsr_shift),
        .gate      (lfsr_gate),
        .fb_in     (fb_bit),
        .par       (par),
        .par_shift (par_shift)
    );

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        tx_clean_n  = 1'b0;
        slot_n      = 3'd0;
        done        = 1'b0;
        capture_par = 1'b0;
        lfsr_clr    = 1'b0;
        lfsr_shift  = 1'b0;
        lfsr_gate   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                state_n = ST_IDLE;
            end
            ST_MSG: begin
                lfsr_shift = 1'b1;
                if (cnt == 2'd3) begin
                    // Next slot is c2 = b2 after this final division step.
                    state_n    = ST_PAR;
                    cnt_n      = 2'd0;
                    tx_clean_n = par_shift[R-1];
                    slot_n     = 3'd4;
                end else begin
                    cnt_n      = cnt + 2'd1;
                    tx_clean_n = msg_q[2'd2 - cnt];
                    slot_n     = {1'b0, cnt} + 3'd1;
                end
            end
            ST_PAR: begin
                lfsr_shift = 1'b1;
                lfsr_gate  = 1'b1;
                if (cnt == 2'd0) begin
                    capture_par = 1'b1;
                end
                if (cnt == 2'd2) begin
                    state_n = ST_IDLE;
                    cnt_n   = 2'd0;
                    done    = 1'b1;
                end else begin
                    // With feedback off, b2 after the shift is today's b1.
                    cnt_n      = cnt + 2'd1;
                    tx_clean_n = par_shift[R-1];
                    slot_n     = {1'b0, cnt} + 3'd5;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 2'd0;
            end
        endcase

        if (accept) begin
            state_n    = ST_MSG;
            cnt_n      = 2'd0;
            tx_clean_n = msg[K-1];
            slot_n     = 3'd0;
            lfsr_clr   = 1'b1;
        end
    end

    assign idx_n = slot_to_index(slot_n);
    assign tx_n  = (state_n != ST_IDLE) & (tx_clean_n ^ err_cur[idx_n]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            cnt            <= 2'd0;
            msg_q          <= '0;
            par_q          <= '0;
            tx_bit         <= 1'b0;
            codeword       <= '0;
            codeword_valid <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            tx_bit         <= tx_n;
            codeword_valid <= done;
            if (accept) begin
                msg_q <= msg;
            end
            if (capture_par) begin
                par_q <= par;
            end
            if (done) begin
                codeword <= {par_q[0], par_q[1], par_q[2],
                             msg_q[0], msg_q[1], msg_q[2], msg_q[3]};
            end
        end
    end

`ifdef MLD_ENC_ERROR_INJECT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= '0;
        end else if (accept) begin
            err_q <= err_mask;
        end
    end
`endif

endmodule

// File: tb/tb_mld_7_4_encoder.sv
// Directed bench for mld_7_4_encoder: table of single frames plus
// back-to-back and mid-frame reset sequences.
module tb_mld_7_4_encoder;

    logic       clk;
    logic       reset;
    logic       msg_valid;
    logic [3:0] msg;
    logic       msg_ready;
    logic       tx_bit;
    logic       tx_load;
    logic [0:6] codeword;
    logic       codeword_valid;
`ifdef MLD_ENC_ERROR_INJECT_EN
    logic [0:6] err_mask;
`endif

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string      name;
        logic [3:0] m;
        logic [0:6] err;
        logic [6:0] stream;
        logic [0:6] cw;
    } vec_t;

    mld_7_4_encoder dut (
        .clk            (clk),
        .reset          (reset),
        .msg_valid      (msg_valid),
        .msg            (msg),
`ifdef MLD_ENC_ERROR_INJECT_EN
        .err_mask       (err_mask),
`endif
        .msg_ready      (msg_ready),
        .tx_bit         (tx_bit),
        .tx_load        (tx_load),
        .codeword       (codeword),
        .codeword_valid (codeword_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v);
        logic [6:0] bits;
        logic [6:0] loads;
        logic [6:0] rdy;
        logic [7:0] cvs;
        @(negedge clk);
        chk({v.name, " ready_before"}, 32'(msg_ready), 32'd1);
        msg_valid = 1'b1;
        msg       = v.m;
`ifdef MLD_ENC_ERROR_INJECT_EN
        err_mask  = v.err;
`endif
        @(negedge clk);
        msg_valid = 1'b0;
        msg       = ~v.m;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            bits[6-i]  = tx_bit;
            loads[6-i] = tx_load;
            rdy[6-i]   = msg_ready;
            cvs[7-i]   = codeword_valid;
        end
        @(negedge clk);
        cvs[0] = codeword_valid;
        chk({v.name, " stream"}, 32'(bits), 32'(v.stream));
        chk({v.name, " tx_load"}, 32'(loads), 32'h7f);
        chk({v.name, " ready_pat"}, 32'(rdy), 32'h01);
        chk({v.name, " cv_pat"}, 32'(cvs), 32'h01);
        chk({v.name, " codeword"}, 32'(codeword), 32'(v.cw));
        chk({v.name, " idle_load"}, {31'd0, tx_load, tx_bit}, 32'd0);
    endtask

    vec_t tbl[$];

    initial begin
        logic [13:0] bb_bits;
        logic [13:0] bb_load;
        logic [13:0] bb_rdy;
        logic [13:0] bb_cv;
        logic [0:6]  cw1;
        logic        cv_seen;
        vec_t        v;

        tbl.push_back('{"m0001", 4'b0001, 7'b0000000, 7'b0001011, 7'b1101000});
        tbl.push_back('{"m0010", 4'b0010, 7'b0000000, 7'b0010110, 7'b0110100});
        tbl.push_back('{"m1111", 4'b1111, 7'b0000000, 7'b1111111, 7'b1111111});
        tbl.push_back('{"m1000", 4'b1000, 7'b0000000, 7'b1000101, 7'b1010001});
        tbl.push_back('{"m0100", 4'b0100, 7'b0000000, 7'b0100111, 7'b1110010});
        tbl.push_back('{"m0000", 4'b0000, 7'b0000000, 7'b0000000, 7'b0000000});
`ifdef MLD_ENC_ERROR_INJECT_EN
        tbl.push_back('{"inj0001", 4'b0001, 7'b0000100, 7'b0011011, 7'b1101000});
`endif

        reset     = 1'b0;
        msg_valid = 1'b0;
        msg       = 4'd0;
`ifdef MLD_ENC_ERROR_INJECT_EN
        err_mask  = '0;
`endif
        repeat (3) @(negedge clk);
        chk("rst msg_ready", 32'(msg_ready), 32'd1);
        chk("rst tx_load", 32'(tx_load), 32'd0);
        chk("rst tx_bit", 32'(tx_bit), 32'd0);
        chk("rst codeword", 32'(codeword), 32'd0);
        chk("rst cw_valid", 32'(codeword_valid), 32'd0);
        reset = 1'b1;

        foreach (tbl[i]) run_frame(tbl[i]);

        // Back-to-back: valid held high, msg changed while not ready.
        @(negedge clk);
        msg_valid = 1'b1;
        msg       = 4'b0001;
        @(negedge clk);
        msg = 4'b0010;
        cw1 = '0;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            bb_bits[13-i] = tx_bit;
            bb_load[13-i] = tx_load;
            bb_rdy[13-i]  = msg_ready;
            bb_cv[13-i]   = codeword_valid;
            if (i == 7) begin
                cw1       = codeword;
                msg_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b stream", 32'(bb_bits), 32'(14'b0001011_0010110));
        chk("b2b tx_load", 32'(bb_load), 32'h3fff);
        chk("b2b ready_pat", 32'(bb_rdy), 32'(14'b0000001_0000001));
        chk("b2b cv_pat", 32'(bb_cv), 32'(14'b0000000_1000000));
        chk("b2b cw1", 32'(cw1), 32'(7'b1101000));
        chk("b2b cw2_valid", 32'(codeword_valid), 32'd1);
        chk("b2b cw2", 32'(codeword), 32'(7'b0110100));
        chk("b2b end_load", 32'(tx_load), 32'd0);

        // Reset while the 4th bit of 1111 is on the line.
        @(negedge clk);
        msg_valid = 1'b1;
        msg       = 4'b1111;
        @(negedge clk);
        msg_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid pre_load", {31'd0, tx_load}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid tx_load", 32'(tx_load), 32'd0);
        chk("mid ready", 32'(msg_ready), 32'd1);
        chk("mid tx_bit", 32'(tx_bit), 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        cv_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cv_seen = cv_seen | codeword_valid | tx_load;
        end
        chk("mid no_cv", 32'(cv_seen), 32'd0);
        chk("mid codeword", 32'(codeword), 32'd0);
        v = '{"post_rst", 4'b0010, 7'b0000000, 7'b0010110, 7'b0110100};
        run_frame(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
